nano_cpu: RTL and testbench
===========================

NANO_CPU -- requirements
Module: nano_cpu

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 ck  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 address  output  8  memory word address.
REQ-005 dataR  input  16  memory read data; combinational from address, valid in the same cycle.
REQ-006 dataW  output  16  memory write data.
REQ-007 ce  output  1  memory access enable; high in FETCH and during READ/WRITE execute.
REQ-008 we  output  1  write enable; memory stores dataW at address on the rising edge where we=1.

Function
REQ-009 State: PC[7:0], IR[15:0], register file R0..R15 of 16 bits; R0 is an ordinary writable register.
REQ-010 Instruction fields: op=IR[15:12]; ALU form t=IR[11:8], s1=IR[7:4], s2=IR[3:0]; memory/branch form addr=IR[11:4], r=IR[3:0].
REQ-011 Opcodes: 0 READ R[r]<=mem[addr]; 1 WRITE mem[addr]<=R[r]; 2 JMP PC<=addr; 3 BRANCH PC<=addr if R[r]!=0; 4 XOR; 5 ADD; 6 SUB (s1-s2); 7 LESS R[t]<=(R[s1]<R[s2]) unsigned, 1 or 0; 8 INC R[t]<=R[s1]+1; 9 DEC R[t]<=R[s1]-1; A-E NOP; F HALT (see REQ-022).
REQ-012 Arithmetic modulo 2^16, no flags; INC/DEC ignore s2.
REQ-013 FSM states FETCH, DECODE, EXEC, HALT; FETCH->DECODE->EXEC->FETCH; every instruction takes exactly 3 cycles.
REQ-014 FETCH: address=PC, ce=1, we=0; on edge IR<=dataR, PC<=PC+1 (wraps 255->0).
REQ-015 DECODE: ce=0, we=0, address=PC; operands R[s1], R[s2], R[r] latched into operand registers.
REQ-016 EXEC READ: address=addr, ce=1, we=0; on edge R[r]<=dataR.
REQ-017 EXEC WRITE: address=addr, dataW=R[r], ce=1, we=1 for exactly that one cycle.
REQ-018 EXEC ALU ops write R[t] on the edge ending EXEC; JMP/BRANCH update PC on that edge; taken branch/jump overrides the FETCH increment.
REQ-019 Outside EXEC WRITE, dataW=16'h0000 and we=0; outside FETCH/READ/WRITE, ce=0.
REQ-020 Operand latching in DECODE means a result written in EXEC is visible to the next instruction.

Reset
REQ-021 While rst=1 at a rising edge: state<=FETCH, PC<=RESET_PC, IR<=0, all registers<=0; outputs address=RESET_PC, dataW=0, we=0, ce=1 in the first post-reset FETCH; reset mid-instruction aborts it with no memory write.

Configuration
REQ-022 Macro NANOCPU_HALT_EN: defined -> opcode F enters HALT (ce=0, we=0, PC frozen) until reset; undefined -> opcode F is a NOP.

Structure
REQ-023 Package nanocpu_pkg holds the opcode enum, FSM state enum, and field-position constants.
REQ-024 One sub-module nanocpu_alu: combinational, inputs op, a, b (16 bit), output 16-bit result for opcodes 4-9.

Verification
REQ-025 Mem[0]=4000,[1]=4111 with R0/R1 preloaded nonzero by a prior READ -> R0=R1=0 after 6 cycles.
REQ-026 Mem[0]=0093, mem[9]=000A, mem[1]=8033 -> R3=10 then R0=11; PC=2 after 6 cycles.
REQ-027 Program READ R3 from mem[9]=10, LESS 7203 (R0=0) -> R2=1; BRANCH 3032 -> PC=3.
REQ-028 BRANCH 3035 with R5=0 -> PC falls through to next address; JMP 2140 -> PC=20.
REQ-029 R1=5, WRITE 10A1 -> we=1 exactly one cycle with address=0A, dataW=0005; mem[10]=5 afterwards.
REQ-030 DEC 9220 with R2=0 -> R2=FFFF; INC of FFFF -> 0000; rst asserted during EXEC of WRITE -> no write, PC=RESET_PC.

Source files
------------

// File: rtl/nanocpu_pkg.sv
// Shared types and instruction-field positions for the nano_cpu core.
package nanocpu_pkg;

    typedef enum logic [3:0] {
        OpRead   = 4'h0,
        OpWrite  = 4'h1,
        OpJmp    = 4'h2,
        OpBranch = 4'h3,
        OpXor    = 4'h4,
        OpAdd    = 4'h5,
        OpSub    = 4'h6,
        OpLess   = 4'h7,
        OpInc    = 4'h8,
        OpDec    = 4'h9,
        OpNopA   = 4'hA,
        OpNopB   = 4'hB,
        OpNopC   = 4'hC,
        OpNopD   = 4'hD,
        OpNopE   = 4'hE,
        OpHalt   = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    localparam int unsigned OpLsb   = 12;
    localparam int unsigned TLsb    = 8;
    localparam int unsigned S1Lsb   = 4;
    localparam int unsigned S2Lsb   = 0;
    localparam int unsigned AddrLsb = 4;
    localparam int unsigned RLsb    = 0;

    function automatic opcode_e get_op(logic [15:0] ir);
        return opcode_e'(ir[OpLsb +: 4]);
    endfunction

endpackage

// File: rtl/nanocpu_alu.sv
// Combinational ALU for opcodes 4-9; other opcodes yield zero.
module nanocpu_alu
    import nanocpu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] result_o
);

    always_comb begin
        result_o = 16'h0000;
        case (opcode_e'(op_i))
            OpXor:   result_o = a_i ^ b_i;
            OpAdd:   result_o = a_i + b_i;
            OpSub:   result_o = a_i - b_i;
            OpLess:  result_o = {15'd0, (a_i < b_i)};
            OpInc:   result_o = a_i + 16'd1;
            OpDec:   result_o = a_i - 16'd1;
            default: result_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/nano_cpu.sv
// Three-cycle (fetch/decode/exec) 16-bit accumulator-free CPU with a 16-entry register file.
// Build option: define NANOCPU_HALT_EN to make opcode F halt the core until reset.
module nano_cpu
    import nanocpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        ck,
    input  logic        rst,
    output logic [7:0]  address,
    input  logic [15:0] dataR,
    output logic [15:0] dataW,
    output logic        ce,
    output logic        we
);

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] opr_q, opr_d;
    logic [15:0] rf_q [16];

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        we_raw;
    logic [15:0] alu_res;

    opcode_e     op;
    logic [3:0]  fld_t, fld_s1, fld_s2, fld_r;
    logic [7:0]  mem_addr;

    assign op       = get_op(ir_q);
    assign fld_t    = ir_q[TLsb +: 4];
    assign fld_s1   = ir_q[S1Lsb +: 4];
    assign fld_s2   = ir_q[S2Lsb +: 4];
    assign fld_r    = ir_q[RLsb +: 4];
    assign mem_addr = ir_q[AddrLsb +: 8];

    nanocpu_alu u_alu (
        .op_i     (ir_q[OpLsb +: 4]),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .result_o (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opr_d    = opr_q;
        rf_we    = 1'b0;
        rf_waddr = fld_t;
        rf_wdata = alu_res;
        address  = pc_q;
        ce       = 1'b0;
        we_raw   = 1'b0;
        dataW    = 16'h0000;
        case (state_q)
            StFetch: begin
                ce      = 1'b1;
                ir_d    = dataR;
                pc_d    = pc_q + 8'd1;
                state_d = StDecode;
            end
            StDecode: begin
                opa_d   = rf_q[fld_s1];
                opb_d   = rf_q[fld_s2];
                opr_d   = rf_q[fld_r];
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpRead: begin
                        address  = mem_addr;
                        ce       = 1'b1;
                        rf_we    = 1'b1;
                        rf_waddr = fld_r;
                        rf_wdata = dataR;
                    end
                    OpWrite: begin
                        address = mem_addr;
                        ce      = 1'b1;
                        we_raw  = 1'b1;
                        dataW   = opr_q;
                    end
                    OpJmp:    pc_d = mem_addr;
                    OpBranch: if (opr_q != 16'h0000) pc_d = mem_addr;
                    OpXor, OpAdd, OpSub, OpLess, OpInc, OpDec: rf_we = 1'b1;
                    OpHalt: begin
`ifdef NANOCPU_HALT_EN
                        state_d = StHalt;
`else
                        state_d = StFetch;
`endif
                    end
                    default: ;
                endcase
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // A reset arriving during a WRITE must not let the memory capture the store.
    assign we = we_raw & ~rst;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            opa_q   <= 16'h0000;
            opb_q   <= 16'h0000;
            opr_q   <= 16'h0000;
            for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opr_q   <= opr_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_nano_cpu.sv
// Directed self-checking bench for nano_cpu with a 256x16 behavioural memory.
module tb_nano_cpu;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  address;
    logic [15:0] dataR;
    logic [15:0] dataW;
    logic        ce;
    logic        we;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    nano_cpu #(.RESET_PC(8'h00)) dut (
        .ck      (ck),
        .rst     (rst),
        .address (address),
        .dataR   (dataR),
        .dataW   (dataW),
        .ce      (ce),
        .we      (we)
    );

    always #5 ck = ~ck;

    assign dataR = mem[address];

    always @(posedge ck) if (we) mem[address] = dataW;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Leaves the core in its first FETCH, sampled at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge ck);
    endtask

    logic [15:0] wr_data;
    logic [7:0]  wr_addr;
    int          we_cnt;

    initial begin
        // Preloaded registers cleared by XOR with themselves
        clear_mem();
        mem[0] = 16'h0200; mem[1] = 16'h0201; mem[2] = 16'h4000; mem[3] = 16'h4111;
        mem[8'h20] = 16'h1234;
        do_reset();
        check_eq("rst_address", {24'd0, address}, 32'h00);
        check_eq("rst_ce", {31'd0, ce}, 32'd1);
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_dataW", {16'd0, dataW}, 32'h0000);
        run(1);
        check_eq("decode_ce", {31'd0, ce}, 32'd0);
        run(5);
        check_eq("pre_r0", {16'd0, dut.rf_q[0]}, 32'h1234);
        check_eq("pre_r1", {16'd0, dut.rf_q[1]}, 32'h1234);
        run(6);
        check_eq("xor_r0", {16'd0, dut.rf_q[0]}, 32'h0000);
        check_eq("xor_r1", {16'd0, dut.rf_q[1]}, 32'h0000);

        // READ then INC sees the freshly written register
        clear_mem();
        mem[0] = 16'h0093; mem[1] = 16'h8033; mem[9] = 16'h000A;
        do_reset();
        run(3);
        check_eq("read_r3", {16'd0, dut.rf_q[3]}, 32'h000A);
        run(3);
        check_eq("inc_r0", {16'd0, dut.rf_q[0]}, 32'h000B);
        check_eq("inc_pc", {24'd0, dut.pc_q}, 32'h02);

        // LESS, taken branch, untaken branch, jump, LESS false
        clear_mem();
        mem[0] = 16'h0093; mem[1] = 16'h7203; mem[2] = 16'h3032;
        mem[3] = 16'h3035; mem[4] = 16'h2140; mem[8'h14] = 16'h7230;
        mem[9] = 16'h000A;
        do_reset();
        run(6);
        check_eq("less_true", {16'd0, dut.rf_q[2]}, 32'h0001);
        run(3);
        check_eq("br_taken_pc", {24'd0, dut.pc_q}, 32'h03);
        run(3);
        check_eq("br_not_taken_pc", {24'd0, dut.pc_q}, 32'h04);
        run(2);
        check_eq("jmp_exec_ce", {31'd0, ce}, 32'd0);
        run(1);
        check_eq("jmp_pc", {24'd0, dut.pc_q}, 32'h14);
        check_eq("jmp_fetch_addr", {24'd0, address}, 32'h14);
        run(3);
        check_eq("less_false", {16'd0, dut.rf_q[2]}, 32'h0000);

        // WRITE pulses we for one cycle with the register value
        clear_mem();
        mem[0] = 16'h0091; mem[1] = 16'h10A1; mem[9] = 16'h0005;
        do_reset();
        we_cnt = 0; wr_addr = 8'h00; wr_data = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                check_eq("read_exec_addr", {24'd0, address}, 32'h09);
                check_eq("read_exec_ce", {31'd0, ce}, 32'd1);
            end
            if (we) begin
                we_cnt++;
                wr_addr = address;
                wr_data = dataW;
            end else begin
                check_eq("dataW_idle", {16'd0, dataW}, 32'h0000);
            end
            @(negedge ck);
        end
        check_eq("we_cycles", we_cnt, 32'd1);
        check_eq("wr_addr", {24'd0, wr_addr}, 32'h0A);
        check_eq("wr_data", {16'd0, wr_data}, 32'h0005);
        check_eq("mem10", {16'd0, mem[10]}, 32'h0005);

        // DEC wraps below zero, INC wraps above FFFF
        clear_mem();
        mem[0] = 16'h9220; mem[1] = 16'h8220; mem[2] = 16'hA123;
        do_reset();
        run(3);
        check_eq("dec_wrap", {16'd0, dut.rf_q[2]}, 32'hFFFF);
        run(3);
        check_eq("inc_wrap", {16'd0, dut.rf_q[2]}, 32'h0000);
        run(3);
        check_eq("nop_pc", {24'd0, dut.pc_q}, 32'h03);

        // Opcode F behaviour depends on the build option
        clear_mem();
        mem[0] = 16'hF000; mem[1] = 16'h8110;
        do_reset();
        run(6);
`ifdef NANOCPU_HALT_EN
        check_eq("halt_pc", {24'd0, dut.pc_q}, 32'h01);
        check_eq("halt_ce", {31'd0, ce}, 32'd0);
        check_eq("halt_r1", {16'd0, dut.rf_q[1]}, 32'h0000);
`else
        check_eq("fnop_pc", {24'd0, dut.pc_q}, 32'h02);
        check_eq("fnop_r1", {16'd0, dut.rf_q[1]}, 32'h0001);
`endif

        // Reset during EXEC of a WRITE suppresses the store
        clear_mem();
        mem[0] = 16'h0091; mem[1] = 16'h10A1; mem[9] = 16'h0007;
        do_reset();
        run(5);
        check_eq("abort_we_before", {31'd0, we}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_we_gated", {31'd0, we}, 32'd0);
        @(negedge ck);
        rst = 1'b0;
        check_eq("abort_mem10", {16'd0, mem[10]}, 32'h0000);
        check_eq("abort_pc", {24'd0, dut.pc_q}, 32'h00);
        check_eq("abort_addr", {24'd0, address}, 32'h00);
        check_eq("abort_ce", {31'd0, ce}, 32'd1);
        check_eq("abort_r1", {16'd0, dut.rf_q[1]}, 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
